sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
Single-clock, AXI-Stream-style FIFO that buffers WIDTH-bit words between a producer (i_*) and a consumer (o_*). It has first-word-fall-through output and a synchronous flush (clear). Live fill-level counters (space, occupied) are provided for flow control and debug. It is a general buffering block placed between streaming pipeline stages.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 512, storage capacity in words; power of two, 2..32768
AFULL_THRESH, DEPTH-4, almost_full threshold (used only with SYNC_FIFO_ALMOST_EN)
AEMPTY_THRESH, 4, almost_empty threshold (used only with SYNC_FIFO_ALMOST_EN)

Ports:
clock  in  1  single clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
clear  in  1  synchronous flush, active-high
i_tdata  in  WIDTH  write data
i_tvalid  in  1  write data valid
i_tready  out  1  FIFO can accept a word (not full)
o_tdata  out  WIDTH  read data (head of FIFO)
o_tvalid  out  1  o_tdata holds a valid word
o_tready  in  1  consumer accepts o_tdata
space  out  16  free words = DEPTH - occupied
occupied  out  16  words held (accepted, not yet consumed)

Behaviour:
- Reset (reset=0, asynchronous): pointers and count cleared; i_tready=1, o_tvalid=0, o_tdata=0, occupied=0, space=DEPTH. Reset mid-operation discards all content immediately. Outputs leave reset on the first edge after reset=1.
- Write: word accepted on a rising edge when i_tvalid && i_tready. Write pointer increments modulo DEPTH and wraps naturally.
- Read: word consumed on a rising edge when o_tvalid && o_tready. Read pointer increments modulo DEPTH.
- i_tready = (occupied != DEPTH), registered/derived from registered state only, with no combinational path from i_tvalid or o_tready.
- o_tvalid = (occupied != 0) after fall-through. A word accepted at edge N into an empty FIFO is visible on o_tdata with o_tvalid=1 after edge N+1, so latency is 1 cycle. No same-cycle bypass.
- o_tdata holds the oldest unread word while o_tvalid=1. When o_tvalid=0, o_tdata keeps its last value.
- Order is strictly first-in-first-out.
- occupied is updated on the edge of the handshake: +1 on write only, -1 on read only, unchanged on simultaneous write and read. occupied may lead o_tvalid by one cycle after a write into empty. space = DEPTH - occupied always.
- Full (occupied=DEPTH): i_tready=0; i_tvalid is ignored. A read in the same cycle frees a slot, and i_tready=1 on the next cycle.
- Empty: o_tvalid=0; o_tready is ignored. No underflow.
- Simultaneous write and read when neither full nor empty: both are performed; occupied is unchanged.
- clear=1 at an edge: empties the FIFO exactly as reset does, and any write or read in that cycle is discarded. clear has priority over handshakes.
- No handshake is ever dropped or duplicated. i_tdata is sampled only on an accepted write.

Optional Feature:
- Macro SYNC_FIFO_ALMOST_EN, when defined, adds two 1-bit outputs:
  - almost_full = (occupied >= AFULL_THRESH)
  - almost_empty = (occupied <= AEMPTY_THRESH)
- Both are registered and consistent with occupied in the same cycle. Reset values: almost_full=0, almost_empty=1.
- Without the macro, these ports and their logic are absent, and AFULL_THRESH and AEMPTY_THRESH are unused.

Test Plan:
1. Basic order: after reset, write 0xA5A5A5A5, 0x5A5A5A5A, 0x12345678 on consecutive cycles with o_tready=0 -> occupied=3, space=509, o_tvalid=1 with o_tdata=0xA5A5A5A5. Then set o_tready=1 -> read 0xA5A5A5A5, 0x5A5A5A5A, 0x12345678 in order, then o_tvalid=0, occupied=0, space=512.
2. Latency: write 0xDEADBEEF into empty FIFO at edge N -> o_tvalid=1 and o_tdata=0xDEADBEEF after edge N+1. Read it -> o_tvalid=0 next cycle.
3. Full/wrap: write 512 words 0..511 -> i_tready=0, space=0, occupied=512. The 513th write is ignored. Read all -> 0..511 in order. Repeat 700 more writes and reads continuously -> data stays in order across pointer wrap.
4. Simultaneous: with 5 words held, i_tvalid=o_tready=1 for 10 cycles -> occupied stays 5. At full with o_tready=1 -> one read, i_tready=1 next cycle.
5. Clear: load 3 words, pulse clear=1 for one cycle with i_tvalid=1 -> occupied=0, space=512, o_tvalid=0, and the written word is discarded.
6. Async reset mid-stream: assert reset=0 between edges while 10 words are held -> outputs go to reset values immediately without a clock edge. After release, a normal write/read works.

Source files
------------

// File: rtl/sync_fifo_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_if
//   Groups the producer/consumer stream signals and the fill-level status of
//   sync_fifo into one bundle.
//   Producer side : i_tdata, i_tvalid -> FIFO ; i_tready <- FIFO
//   Consumer side : o_tdata, o_tvalid <- FIFO ; o_tready -> FIFO
//   Status        : space, occupied (16 bit each)
//   Optional      : almost_full, almost_empty (present when SYNC_FIFO_ALMOST_EN
//                   is defined)
//   Modports      : slave  - the FIFO itself
//                   master - the environment (producer + consumer + monitor)
// ---------------------------------------------------------------------------
interface sync_fifo_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] i_tdata;
  logic             i_tvalid;
  logic             i_tready;
  logic [WIDTH-1:0] o_tdata;
  logic             o_tvalid;
  logic             o_tready;
  logic [15:0]      space;
  logic [15:0]      occupied;
`ifdef SYNC_FIFO_ALMOST_EN
  logic             almost_full;
  logic             almost_empty;
`endif

  modport slave (
    input  i_tdata, i_tvalid, o_tready,
`ifdef SYNC_FIFO_ALMOST_EN
    output almost_full, almost_empty,
`endif
    output i_tready, o_tdata, o_tvalid, space, occupied
  );

  modport master (
    output i_tdata, i_tvalid, o_tready,
`ifdef SYNC_FIFO_ALMOST_EN
    input  almost_full, almost_empty,
`endif
    input  i_tready, o_tdata, o_tvalid, space, occupied
  );
endinterface

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock first-word-fall-through stream FIFO with synchronous flush.
//   Storage is a DEPTH-entry RAM followed by a one-word output register that
//   presents the head of the queue on o_tdata. A word written into an empty
//   FIFO reaches the output register one edge later (no same-cycle bypass).
//
//   Ports:
//     clock  - rising-edge clock
//     reset  - asynchronous, active-low reset
//     clear  - synchronous flush, active-high, wins over any handshake
//     fifo   - sync_fifo_if.slave: i_* write stream, o_* read stream,
//              space/occupied fill levels (and almost_* when enabled)
//
//   Optional feature: define SYNC_FIFO_ALMOST_EN to add registered
//   almost_full (occupied >= AFULL_THRESH) and almost_empty
//   (occupied <= AEMPTY_THRESH) outputs.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 512,   // power of two, 2..32768
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  sync_fifo_if.slave  fifo
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;          // occupied counts 0..DEPTH inclusive

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    occ_q, occ_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic             full;
  logic             wr_en;
  logic             rd_en;
  logic             load;
  logic [CW-1:0]    mem_cnt;

  // i_tready depends only on registered state, never on i_tvalid/o_tready.
  assign full  = (occ_q == CW'(DEPTH));
  assign wr_en = fifo.i_tvalid && !full;
  assign rd_en = out_valid_q && fifo.o_tready;

  // Words sitting in the RAM behind the output register. Only these may be
  // moved forward; a word written at this very edge is not yet counted as
  // readable, which yields the one-cycle fall-through latency.
  assign mem_cnt = occ_q - CW'(out_valid_q);
  assign load    = (mem_cnt != '0) && (!out_valid_q || fifo.o_tready);

  // NOTE: every variable assigned here gets its default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      occ_d       = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + 1'b1;     // power-of-two depth wraps naturally
      end

      if (load) begin
        out_data_d  = mem[rd_ptr_q];
        out_valid_d = 1'b1;
        rd_ptr_d    = rd_ptr_q + 1'b1;
      end else if (rd_en) begin
        out_valid_d = 1'b0;             // o_tdata keeps its last value
      end

      unique case ({wr_en, rd_en})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // NOTE: the storage array has no reset; its contents are never observed
  // until written, and leaving it out lets it map onto RAM.
  always_ff @(posedge clock) begin
    if (wr_en && !clear) begin
      mem[wr_ptr_q] <= fifo.i_tdata;
    end
  end

  assign fifo.i_tready = !full;
  assign fifo.o_tvalid = out_valid_q;
  assign fifo.o_tdata  = out_data_q;
  assign fifo.occupied = 16'(occ_q);
  assign fifo.space    = 16'(DEPTH) - 16'(occ_q);

`ifdef SYNC_FIFO_ALMOST_EN
  // Flags are computed from the next count so they change on the same edge
  // as occupied.
  logic almost_full_q, almost_empty_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= (int'(occ_d) >= AFULL_THRESH);
      almost_empty_q <= (int'(occ_d) <= AEMPTY_THRESH);
    end
  end

  assign fifo.almost_full  = almost_full_q;
  assign fifo.almost_empty = almost_empty_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo
//   Directed self-checking bench for sync_fifo (WIDTH=32, DEPTH=512).
//   Inputs are driven 1 ns after the rising edge; outputs are sampled at the
//   same point, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_sync_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 512;

  logic clock;
  logic reset;
  logic clear;

  int n_checks;
  int n_fail;

  sync_fifo_if #(.WIDTH(WIDTH)) bus ();

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .fifo  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_tvalid = 1'b0;
    bus.i_tdata  = '0;
    bus.o_tready = 1'b0;
    clear        = 1'b0;
  endtask

  // Expects all outputs at their reset/clear values.
  task automatic expect_empty_state(input string tag);
    n_checks++;
    if (bus.occupied !== 16'd0 || bus.space !== 16'd512 || bus.i_tready !== 1'b1 ||
        bus.o_tvalid !== 1'b0 || bus.o_tdata !== 32'h0) begin
      n_fail++;
      $display("FAIL %s: occ=%0d space=%0d i_tready=%b o_tvalid=%b o_tdata=%h, required occ=0 space=512 i_tready=1 o_tvalid=0 o_tdata=0",
               tag, bus.occupied, bus.space, bus.i_tready, bus.o_tvalid, bus.o_tdata);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    #1;
    expect_empty_state("reset_state");
`ifdef SYNC_FIFO_ALMOST_EN
    n_checks++;
    if (bus.almost_full !== 1'b0 || bus.almost_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_almost: af=%b ae=%b, required af=0 ae=1", bus.almost_full, bus.almost_empty);
    end
`endif
    tick();
    tick();
    reset = 1'b1;
    tick();
    expect_empty_state("after_reset_release");
  endtask

  task automatic test_basic_order();
    logic [31:0] exp_words [3];
    exp_words[0] = 32'hA5A5_A5A5;
    exp_words[1] = 32'h5A5A_5A5A;
    exp_words[2] = 32'h1234_5678;
    bus.o_tready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.i_tvalid = 1'b1;
      bus.i_tdata  = exp_words[k];
      tick();
    end
    bus.i_tvalid = 1'b0;
    n_checks++;
    if (bus.occupied !== 16'd3 || bus.space !== 16'd509 || bus.o_tvalid !== 1'b1 ||
        bus.o_tdata !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL basic_loaded: occ=%0d space=%0d o_tvalid=%b o_tdata=%h, required 3 509 1 a5a5a5a5",
               bus.occupied, bus.space, bus.o_tvalid, bus.o_tdata);
    end
    bus.o_tready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (bus.o_tvalid !== 1'b1 || bus.o_tdata !== exp_words[k]) begin
        n_fail++;
        $display("FAIL basic_read%0d: o_tvalid=%b o_tdata=%h, required 1 %h",
                 k, bus.o_tvalid, bus.o_tdata, exp_words[k]);
      end
      tick();
    end
    bus.o_tready = 1'b0;
    n_checks++;
    if (bus.o_tvalid !== 1'b0 || bus.occupied !== 16'd0 || bus.space !== 16'd512 ||
        bus.o_tdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL basic_drained: o_tvalid=%b occ=%0d space=%0d o_tdata=%h, required 0 0 512 12345678 (held)",
               bus.o_tvalid, bus.occupied, bus.space, bus.o_tdata);
    end
  endtask

  task automatic test_latency();
    bus.i_tvalid = 1'b1;
    bus.i_tdata  = 32'hDEAD_BEEF;
    tick();                                   // edge N: accepted
    bus.i_tvalid = 1'b0;
    n_checks++;
    if (bus.o_tvalid !== 1'b0 || bus.occupied !== 16'd1) begin
      n_fail++;
      $display("FAIL latency_edge_n: o_tvalid=%b occ=%0d, required 0 1", bus.o_tvalid, bus.occupied);
    end
    tick();                                   // edge N+1: visible
    n_checks++;
    if (bus.o_tvalid !== 1'b1 || bus.o_tdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL latency_edge_n1: o_tvalid=%b o_tdata=%h, required 1 deadbeef", bus.o_tvalid, bus.o_tdata);
    end
    bus.o_tready = 1'b1;
    tick();
    bus.o_tready = 1'b0;
    n_checks++;
    if (bus.o_tvalid !== 1'b0 || bus.occupied !== 16'd0) begin
      n_fail++;
      $display("FAIL latency_read: o_tvalid=%b occ=%0d, required 0 0", bus.o_tvalid, bus.occupied);
    end
  endtask

  task automatic test_full_wrap();
    int wr_idx;
    int rd_idx;
    int cyc;
    bus.o_tready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.i_tvalid = 1'b1;
      bus.i_tdata  = 32'(k);
      tick();
    end
    n_checks++;
    if (bus.i_tready !== 1'b0 || bus.space !== 16'd0 || bus.occupied !== 16'd512) begin
      n_fail++;
      $display("FAIL full_flags: i_tready=%b space=%0d occ=%0d, required 0 0 512",
               bus.i_tready, bus.space, bus.occupied);
    end
    bus.i_tdata = 32'h0000_0999;              // 513th write, must be ignored
    tick();
    bus.i_tvalid = 1'b0;
    n_checks++;
    if (bus.occupied !== 16'd512 || bus.o_tdata !== 32'h0) begin
      n_fail++;
      $display("FAIL full_overflow: occ=%0d head=%h, required 512 0", bus.occupied, bus.o_tdata);
    end
    bus.o_tready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      n_checks++;
      if (bus.o_tvalid !== 1'b1 || bus.o_tdata !== 32'(k)) begin
        n_fail++;
        $display("FAIL full_drain[%0d]: o_tvalid=%b o_tdata=%h, required 1 %h", k, bus.o_tvalid, bus.o_tdata, 32'(k));
      end
      tick();
    end
    n_checks++;
    if (bus.o_tvalid !== 1'b0 || bus.occupied !== 16'd0) begin
      n_fail++;
      $display("FAIL full_drained: o_tvalid=%b occ=%0d, required 0 0", bus.o_tvalid, bus.occupied);
    end
    // Continuous streaming across the pointer wrap.
    wr_idx = 0;
    rd_idx = 0;
    cyc    = 0;
    while (rd_idx < 700 && cyc < 2000) begin
      bus.i_tvalid = (wr_idx < 700);
      bus.i_tdata  = 32'(1000 + wr_idx);
      if (bus.o_tvalid === 1'b1) begin
        n_checks++;
        if (bus.o_tdata !== 32'(1000 + rd_idx)) begin
          n_fail++;
          $display("FAIL wrap_stream[%0d]: o_tdata=%h, required %h", rd_idx, bus.o_tdata, 32'(1000 + rd_idx));
        end
        rd_idx++;
      end
      if (bus.i_tvalid && bus.i_tready === 1'b1) wr_idx++;
      tick();
      cyc++;
    end
    bus.i_tvalid = 1'b0;
    bus.o_tready = 1'b0;
    n_checks++;
    if (rd_idx != 700 || bus.occupied !== 16'd0) begin
      n_fail++;
      $display("FAIL wrap_done: words read=%0d occ=%0d, required 700 0", rd_idx, bus.occupied);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] model [$];
    bus.o_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.i_tvalid = 1'b1;
      bus.i_tdata  = 32'h100 + 32'(k);
      model.push_back(32'h100 + 32'(k));
      tick();
    end
    bus.i_tvalid = 1'b0;
    tick();
    bus.i_tvalid = 1'b1;
    bus.o_tready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      logic [31:0] exp_head;
      bus.i_tdata = 32'h200 + 32'(k);
      exp_head = model.pop_front();
      model.push_back(32'h200 + 32'(k));
      n_checks++;
      if (bus.o_tvalid !== 1'b1 || bus.o_tdata !== exp_head) begin
        n_fail++;
        $display("FAIL simul_data[%0d]: o_tvalid=%b o_tdata=%h, required 1 %h", k, bus.o_tvalid, bus.o_tdata, exp_head);
      end
      tick();
      n_checks++;
      if (bus.occupied !== 16'd5) begin
        n_fail++;
        $display("FAIL simul_occ[%0d]: occ=%0d, required 5", k, bus.occupied);
      end
    end
    bus.i_tvalid = 1'b0;
    for (int k = 0; k < 20 && bus.occupied !== 16'd0; k++) tick();
    bus.o_tready = 1'b0;
    n_checks++;
    if (bus.occupied !== 16'd0 || bus.o_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_drain: occ=%0d o_tvalid=%b, required 0 0", bus.occupied, bus.o_tvalid);
    end
    // Read while full: exactly one word leaves, write attempt is ignored.
    for (int k = 0; k < DEPTH; k++) begin
      bus.i_tvalid = 1'b1;
      bus.i_tdata  = 32'h4000 + 32'(k);
      tick();
    end
    bus.i_tdata  = 32'hBAD0_BAD0;
    bus.o_tready = 1'b1;
    tick();
    bus.i_tvalid = 1'b0;
    bus.o_tready = 1'b0;
    n_checks++;
    if (bus.occupied !== 16'd511 || bus.i_tready !== 1'b1 || bus.o_tdata !== 32'h4001) begin
      n_fail++;
      $display("FAIL full_read: occ=%0d i_tready=%b head=%h, required 511 1 00004001",
               bus.occupied, bus.i_tready, bus.o_tdata);
    end
`ifdef SYNC_FIFO_ALMOST_EN
    n_checks++;
    if (bus.almost_full !== 1'b1 || bus.almost_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL almost_at_511: af=%b ae=%b, required af=1 ae=0", bus.almost_full, bus.almost_empty);
    end
`endif
  endtask

  task automatic test_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    expect_empty_state("clear_from_511");
    for (int k = 0; k < 3; k++) begin
      bus.i_tvalid = 1'b1;
      bus.i_tdata  = 32'h31 + 32'(k);
      tick();
    end
    bus.i_tvalid = 1'b0;
    tick();
    clear        = 1'b1;
    bus.i_tvalid = 1'b1;
    bus.i_tdata  = 32'h77;
    bus.o_tready = 1'b1;
    tick();
    clear        = 1'b0;
    bus.i_tvalid = 1'b0;
    bus.o_tready = 1'b0;
    expect_empty_state("clear_pulse");
    tick();
    tick();
    expect_empty_state("clear_discard");
    bus.i_tvalid = 1'b1;
    bus.i_tdata  = 32'h88;
    tick();
    bus.i_tvalid = 1'b0;
    tick();
    n_checks++;
    if (bus.o_tvalid !== 1'b1 || bus.o_tdata !== 32'h88 || bus.occupied !== 16'd1) begin
      n_fail++;
      $display("FAIL clear_next_write: o_tvalid=%b o_tdata=%h occ=%0d, required 1 00000088 1",
               bus.o_tvalid, bus.o_tdata, bus.occupied);
    end
  endtask

  task automatic test_async_reset();
    // One word (0x88) is already held; add nine more to reach ten.
    for (int k = 0; k < 9; k++) begin
      bus.i_tvalid = 1'b1;
      bus.i_tdata  = 32'h500 + 32'(k);
      tick();
    end
    bus.i_tvalid = 1'b0;
    n_checks++;
    if (bus.occupied !== 16'd10) begin
      n_fail++;
      $display("FAIL async_preload: occ=%0d, required 10", bus.occupied);
    end
    #2;
    reset = 1'b0;                             // mid-cycle, no clock edge
    #1;
    expect_empty_state("async_reset");
    tick();
    reset = 1'b1;
    tick();
    bus.i_tvalid = 1'b1;
    bus.i_tdata  = 32'hCAFE_0001;
    tick();
    bus.i_tvalid = 1'b0;
    tick();
    n_checks++;
    if (bus.o_tvalid !== 1'b1 || bus.o_tdata !== 32'hCAFE_0001 || bus.occupied !== 16'd1) begin
      n_fail++;
      $display("FAIL async_recover_write: o_tvalid=%b o_tdata=%h occ=%0d, required 1 cafe0001 1",
               bus.o_tvalid, bus.o_tdata, bus.occupied);
    end
    bus.o_tready = 1'b1;
    tick();
    bus.o_tready = 1'b0;
    n_checks++;
    if (bus.o_tvalid !== 1'b0 || bus.occupied !== 16'd0 || bus.space !== 16'd512) begin
      n_fail++;
      $display("FAIL async_recover_read: o_tvalid=%b occ=%0d space=%0d, required 0 0 512",
               bus.o_tvalid, bus.occupied, bus.space);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic_order();
    test_latency();
    test_full_wrap();
    test_simultaneous();
    test_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
